// File: rtl/led_scan_driver.sv
// Time-multiplexed 7-segment scan driver with frame-aligned shadow buffer and leading-zero blanking.
// Define HEX_EN to decode values 10..15 as A,b,C,d,E,F instead of a minus sign.
module led_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int CNT_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   bin_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [7:0]            led,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);
  localparam int IDX_W = $clog2(DIGITS);

  logic [CNT_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_bin_q, disp_bin_q, disp_bin_d;
  logic [DIGITS-1:0]   pend_dp_q, disp_dp_q, disp_dp_d;
  logic [7:0]          led_q, led_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic                fd_q;
  logic                tc, wrap;
  logic [DIGITS:0]     hi_zero;
  logic [DIGITS-1:0]   blank_vec;
  logic [3:0]          cur_val;

  function automatic logic [6:0] seg(input logic [3:0] v);
    case (v)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
`ifdef HEX_EN
      4'd10: seg = 7'b1110111;
      4'd11: seg = 7'b0011111;
      4'd12: seg = 7'b1001110;
      4'd13: seg = 7'b0111101;
      4'd14: seg = 7'b1001111;
      default: seg = 7'b1000111;
`else
      default: seg = 7'b0000001;
`endif
    endcase
  endfunction

  assign tc   = (pre_q == CNT_W'(SCAN_DIV - 1));
  assign wrap = tc && (idx_q == IDX_W'(DIGITS - 1));

  // hi_zero[k]: digit k and every digit above it are zero
  assign hi_zero[DIGITS] = 1'b1;
  assign blank_vec[0]    = 1'b0;
  for (genvar k = DIGITS - 1; k >= 0; k--) begin : g_lz
    assign hi_zero[k] = hi_zero[k+1] && (disp_bin_q[4*k +: 4] == 4'd0);
    if (k > 0) begin : g_bl
      assign blank_vec[k] = blank_lz && hi_zero[k];
    end
  end

  always_comb begin
    pre_d      = tc ? '0 : pre_q + 1'b1;
    idx_d      = idx_q;
    disp_bin_d = disp_bin_q;
    disp_dp_d  = disp_dp_q;
    if (tc) idx_d = wrap ? '0 : idx_q + 1'b1;
    // A load coinciding with the boundary bypasses the pending buffer
    if (wrap) begin
      disp_bin_d = load ? bin_in : pend_bin_q;
      disp_dp_d  = load ? dp_in  : pend_dp_q;
    end
    cur_val = disp_bin_q[4*int'(idx_q) +: 4];
    sel_d   = DIGITS'(1) << idx_q;
    led_d   = {blank_vec[idx_q] ? 7'b0 : seg(cur_val), disp_dp_q[idx_q]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      idx_q      <= '0;
      pend_bin_q <= '0;
      pend_dp_q  <= '0;
      disp_bin_q <= '0;
      disp_dp_q  <= '0;
      led_q      <= '0;
      sel_q      <= '0;
      fd_q       <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      disp_bin_q <= disp_bin_d;
      disp_dp_q  <= disp_dp_d;
      if (load) begin
        pend_bin_q <= bin_in;
        pend_dp_q  <= dp_in;
      end
      led_q      <= led_d;
      sel_q      <= sel_d;
      fd_q       <= wrap;
    end
  end

  assign led        = led_q;
  assign digit_sel  = sel_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver: DIGITS=4, SCAN_DIV=4, so one frame is 16 clocks.
module tb_led_scan_driver;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bin_in;
  logic [3:0]  dp_in;
  logic        load, blank_lz;
  logic [7:0]  led;
  logic [3:0]  digit_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int ec     = 0;

  led_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .led(led), .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic tick_to(input int n);
    while (ec < n) tick();
  endtask

  task automatic chk(input string tag, input logic [3:0] sel_e, input logic [7:0] led_e, input logic fd_e);
    checks++;
    assert ({digit_sel, led, frame_done} === {sel_e, led_e, fd_e}) else begin
      errors++;
      $error("FAIL %s sel=%b led=%b fd=%b expected sel=%b led=%b fd=%b",
             tag, digit_sel, led, frame_done, sel_e, led_e, fd_e);
    end
  endtask

  initial begin
    rst_n = 1'b0; bin_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
    repeat (2) tick();
    chk("reset", 4'b0000, 8'h00, 1'b0);
    rst_n = 1'b1;
    ec = 0;

    // Free-running scan with an all-zero display
    tick();        chk("first", 4'b0001, 8'hFC, 1'b0);
    tick_to(4);    chk("d0_hold", 4'b0001, 8'hFC, 1'b0);
    tick_to(5);    chk("d1", 4'b0010, 8'hFC, 1'b0);
    tick_to(9);    chk("d2", 4'b0100, 8'hFC, 1'b0);
    tick_to(13);   chk("d3", 4'b1000, 8'hFC, 1'b0);
    tick_to(16);   chk("fd1", 4'b1000, 8'hFC, 1'b1);
    tick_to(17);   chk("fd1_clr", 4'b0001, 8'hFC, 1'b0);

    // Mid-frame load must wait for the next frame
    tick_to(20);
    bin_in = 16'h1234; load = 1'b1;
    tick();
    load = 1'b0; bin_in = '0;
    tick_to(25);   chk("mid_d2", 4'b0100, 8'hFC, 1'b0);
    tick_to(29);   chk("mid_d3", 4'b1000, 8'hFC, 1'b0);
    tick_to(32);   chk("fd2", 4'b1000, 8'hFC, 1'b1);
    tick_to(33);   chk("v_d0", 4'b0001, 8'h66, 1'b0);
    tick_to(37);   chk("v_d1", 4'b0010, 8'hF2, 1'b0);
    tick_to(41);   chk("v_d2", 4'b0100, 8'hDA, 1'b0);
    tick_to(45);   chk("v_d3", 4'b1000, 8'h60, 1'b0);

    // Leading-zero blanking with a decimal point on a blanked digit
    tick_to(48);
    blank_lz = 1'b1; bin_in = 16'h0050; dp_in = 4'b1000; load = 1'b1;
    tick();
    load = 1'b0; bin_in = '0; dp_in = '0;
    tick_to(65);   chk("lz_d0", 4'b0001, 8'hFC, 1'b0);
    tick_to(69);   chk("lz_d1", 4'b0010, 8'hB6, 1'b0);
    tick_to(73);   chk("lz_d2", 4'b0100, 8'h00, 1'b0);
    tick_to(77);   chk("lz_d3", 4'b1000, 8'h01, 1'b0);

    // Values above 9
    tick_to(80);
    bin_in = 16'h00AF; load = 1'b1;
    tick();
    load = 1'b0; bin_in = '0;
`ifdef HEX_EN
    tick_to(97);   chk("hx_d0", 4'b0001, 8'h8E, 1'b0);
    tick_to(101);  chk("hx_d1", 4'b0010, 8'hEE, 1'b0);
`else
    tick_to(97);   chk("hx_d0", 4'b0001, 8'h02, 1'b0);
    tick_to(101);  chk("hx_d1", 4'b0010, 8'h02, 1'b0);
`endif
    tick_to(105);  chk("hx_d2", 4'b0100, 8'h00, 1'b0);
    tick_to(109);  chk("hx_d3", 4'b1000, 8'h00, 1'b0);

    // Load exactly in the boundary cycle goes straight to the display
    tick_to(111);
    bin_in = 16'h9999; load = 1'b1;
    tick();        chk("bnd_fd", 4'b1000, 8'h00, 1'b1);
    load = 1'b0; bin_in = '0;
    tick_to(113);  chk("bnd_d0", 4'b0001, 8'hF6, 1'b0);
    tick_to(117);  chk("bnd_d1", 4'b0010, 8'hF6, 1'b0);
    tick_to(121);  chk("bnd_d2", 4'b0100, 8'hF6, 1'b0);
    tick_to(125);  chk("bnd_d3", 4'b1000, 8'hF6, 1'b0);
    tick_to(128);  chk("pre_rst", 4'b1000, 8'hF6, 1'b1);

    // Asynchronous reset while outputs are active
    rst_n = 1'b0;
    #1;            chk("async_rst", 4'b0000, 8'h00, 1'b0);
    repeat (2) tick();
    chk("rst_hold", 4'b0000, 8'h00, 1'b0);
    rst_n = 1'b1;
    ec = 0;
    tick();        chk("rel_d0", 4'b0001, 8'hFC, 1'b0);
    tick_to(5);    chk("rel_d1", 4'b0010, 8'h00, 1'b0);
    tick_to(16);   chk("rel_fd", 4'b1000, 8'h00, 1'b1);
    tick_to(17);   chk("rel_lost", 4'b0001, 8'hFC, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/led_scan_driver.md
Name: led_scan_driver

Overview:
- Time-multiplexed driver for a row of DIGITS common-select 7-segment displays.
- Takes packed 4-bit per-digit values and decimal points, and captures them on a load strobe.
- Shadow-buffers the captured values so the display changes only at a frame boundary, never mid-frame.
- Scans one digit at a time with a programmable dwell; decodes the same segment code set the team uses for single-digit decode, plus optional leading-zero blanking.

Parameters:
- DIGITS, 4: number of digits scanned; legal range 2..8.
- SCAN_DIV, 1000: clocks each digit stays selected; ≥2.
- CNT_W, 10: prescaler width; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- bin_in  input  4*DIGITS  digit values; digit i = bin_in[4i+3:4i]; digit 0 is rightmost/LSD.
- dp_in  input  DIGITS  decimal point per digit, 1 = lit.
- load  input  1  capture bin_in/dp_in into the pending buffer this cycle.
- blank_lz  input  1  leading-zero blanking enable, sampled every cycle.
- led  output  8  segments {a,b,c,d,e,f,g,dp}; a = bit 7; active-high; registered.
- digit_sel  output  DIGITS  one-hot digit enable, active-high; registered.
- frame_done  output  1  one-cycle pulse on scan wrap; registered.

Behaviour:
- Reset (rst_n=0, async):
  - Prescaler, digit index, pending buffer, display buffer all go to 0.
  - led=0, digit_sel=0, frame_done=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 and wraps to 0.
  - Terminal count (TC) = prescaler==SCAN_DIV-1.
- Digit index:
  - Advances on TC; wraps DIGITS-1 → 0.
  - The wrap is the frame boundary.
- frame_done: 1 in the cycle after the wrap TC; 0 otherwise.
- Pending buffer: load=1 captures bin_in and dp_in at the clock edge; load may be held high.
- Display buffer:
  - Updated only at the frame boundary.
  - If load=1 in the boundary cycle, it takes bin_in/dp_in directly; otherwise it takes the pending buffer.
  - Loads mid-frame never alter the digits being shown.
- Output register, every cycle from the current index k and the display buffer:
  - digit_sel = 1<<k.
  - led[7:1] = seg(value k); led[0] = dp bit k.
  - Latency: one cycle from an index change to the new led/digit_sel.
- seg() code, bits a..g then dp=0:
  - 0 11111100, 1 01100000, 2 11011010, 3 11110010, 4 01100110
  - 5 10110110, 6 10111110, 7 11100000, 8 11111110, 9 11110110
  - 10..15: 00000010 (minus sign).
- Leading-zero blanking, when blank_lz=1:
  - Digit k is blanked if its value is 0 and every digit above k is 0.
  - Digit 0 is never blanked.
  - Blanked digit: led[7:1]=0; dp still honoured; digit_sel still asserted.
- First cycle after reset release: digit_sel=…0001, led=11111100 (display buffer all zero; digit 0 never blanked).
- Reset mid-frame: immediate return to reset state; the pending load is lost.

Optional Feature:
- HEX_EN defined: values 10..15 decode to A,b,C,d,E,F:
  - 11101110, 00111110, 10011100, 01111010, 10011110, 10001110.
  - Leading-zero rule unchanged.
- HEX_EN undefined: 10..15 show minus sign 00000010.

Test Plan:
- SCAN_DIV=4, DIGITS=4, reset release → digit_sel steps 0001,0010,0100,1000,0001 every 4 clocks; frame_done pulses once per 16 clocks; all led=11111100.
- load bin_in=16'h1234 mid-frame → current frame still shows 0s; from the next frame, digit 3..0 show 01100000, 11011010, 11110010, 01100110.
- blank_lz=1, bin_in=16'h0050, dp_in=4'b1000:
  - digit3 led=00000001.
  - digit2 led=00000000.
  - digit1 led=10110110.
  - digit0 led=11111100.
- bin_in=16'h00AF without HEX_EN → digits 1,0 show 00000010; with HEX_EN → 11101110 and 10001110.
- load asserted exactly in the boundary cycle with 16'h9999 → the next frame shows 11110110 on all digits, with no frame of stale pending data.
- rst_n dropped mid-digit → led, digit_sel and frame_done are 0 asynchronously; after release, scan restarts at digit 0 with display 0000.
